// File: rtl/icache_mem_prefetch.sv
// icache_mem_prefetch: adapts the instruction cache's word-at-a-time refill
// port to the native valid/ready memory bus. It keeps a single-word buffer
// and fetches the next word of the current line ahead of time, so that
// sequential refill words are usually served without waiting on the bus.
//
// Ports:
//   clk, reset           rising-edge clock, synchronous active-high reset
//   req_valid/req_addr   refill request from the cache (held until req_ready)
//   req_ready/req_rdata  one-cycle completion pulse with the refill word
//   mem_valid/mem_addr   bus request, held stable until mem_ready
//   mem_ready/mem_rdata  bus completion with read data
//   mem_instr            tied high: every access is an instruction fetch
//   pf_hit_count         saturating count of requests served from the buffer
module icache_mem_prefetch #(
  parameter int unsigned LINE_WORDS  = 4,
  parameter bit          PREFETCH_EN = 1'b1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [31:0] req_addr,
  output logic [31:0] req_rdata,
  output logic        mem_valid,
  input  logic        mem_ready,
  output logic [31:0] mem_addr,
  input  logic [31:0] mem_rdata,
  output logic        mem_instr,
  output logic [31:0] pf_hit_count
);

  localparam int unsigned WIDX_W = $clog2(LINE_WORDS);
  localparam int unsigned TAG_W  = 30;
  localparam logic [WIDX_W-1:0] LAST_IDX = WIDX_W'(LINE_WORDS - 1);

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_FETCH    = 2'd1,
    ST_PREFETCH = 2'd2
  } state_t;

  state_t           state, state_d;
  logic             req_ready_d;
  logic [31:0]      req_rdata_d;
  logic             mem_valid_d;
  logic [31:0]      mem_addr_d;
  logic             pf_valid, pf_valid_d;
  logic [TAG_W-1:0] pf_addr, pf_addr_d;
  logic [31:0]      pf_data, pf_data_d;
  logic [31:0]      pf_hit_count_d;
  logic [TAG_W-1:0] req_tag;
  logic             addr_lsb_unused;

  assign mem_instr       = 1'b1;
  assign req_tag         = req_addr[31:2];
  assign addr_lsb_unused = ^req_addr[1:0];

  // True when the address selects the final word of its cache line.
  function automatic logic is_last(input logic [31:0] a);
    return a[WIDX_W+1:2] == LAST_IDX;
  endfunction

  // State and output registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      state        <= ST_IDLE;
      req_ready    <= 1'b0;
      req_rdata    <= 32'd0;
      mem_valid    <= 1'b0;
      mem_addr     <= 32'd0;
      pf_valid     <= 1'b0;
      pf_addr      <= '0;
      pf_data      <= 32'd0;
      pf_hit_count <= 32'd0;
    end else begin
      state        <= state_d;
      req_ready    <= req_ready_d;
      req_rdata    <= req_rdata_d;
      mem_valid    <= mem_valid_d;
      mem_addr     <= mem_addr_d;
      pf_valid     <= pf_valid_d;
      pf_addr      <= pf_addr_d;
      pf_data      <= pf_data_d;
      pf_hit_count <= pf_hit_count_d;
    end
  end

  // Next-state and next-output logic.
  always_comb begin
    state_d        = state;
    req_ready_d    = 1'b0;
    req_rdata_d    = req_rdata;
    mem_valid_d    = mem_valid;
    mem_addr_d     = mem_addr;
    pf_valid_d     = pf_valid;
    pf_addr_d      = pf_addr;
    pf_data_d      = pf_data;
    pf_hit_count_d = pf_hit_count;

    unique case (state)
      ST_IDLE: begin
        // req_ready high means the cache has just been served and its
        // valid is still up for this cycle; ignore it.
        if (req_valid && !req_ready) begin
          if (pf_valid && (pf_addr == req_tag)) begin
            req_ready_d = 1'b1;
            req_rdata_d = pf_data;
            pf_valid_d  = 1'b0;
            if (pf_hit_count != '1) begin
              pf_hit_count_d = pf_hit_count + 32'd1;
            end
            if (PREFETCH_EN && !is_last(req_addr)) begin
              state_d     = ST_PREFETCH;
              mem_valid_d = 1'b1;
              mem_addr_d  = {req_tag + TAG_W'(1), 2'b00};
            end
          end else begin
            pf_valid_d  = 1'b0;
            mem_valid_d = 1'b1;
            mem_addr_d  = {req_tag, 2'b00};
            state_d     = ST_FETCH;
          end
        end
      end

      ST_FETCH: begin
        if (mem_ready) begin
          mem_valid_d = 1'b0;
          if (req_valid && (req_tag == mem_addr[31:2])) begin
            req_ready_d = 1'b1;
            req_rdata_d = mem_rdata;
            if (PREFETCH_EN && !is_last(mem_addr)) begin
              // The demand transaction has completed, so the prefetch is
              // issued back-to-back as a fresh bus request.
              state_d     = ST_PREFETCH;
              mem_valid_d = 1'b1;
              mem_addr_d  = mem_addr + 32'd4;
            end else begin
              state_d = ST_IDLE;
            end
          end else begin
            // Requester went away or moved on: keep the word in case it
            // comes back for it.
            pf_valid_d = 1'b1;
            pf_addr_d  = mem_addr[31:2];
            pf_data_d  = mem_rdata;
            state_d    = ST_IDLE;
          end
        end
      end

      ST_PREFETCH: begin
        // Any demand request waits here; IDLE evaluates it next cycle.
        if (mem_ready) begin
          mem_valid_d = 1'b0;
          pf_valid_d  = 1'b1;
          pf_addr_d   = mem_addr[31:2];
          pf_data_d   = mem_rdata;
          state_d     = ST_IDLE;
        end
      end

      default: begin
        state_d     = ST_IDLE;
        mem_valid_d = 1'b0;
      end
    endcase
  end

endmodule

// File: tb/tb_icache_mem_prefetch.sv
module tb_icache_mem_prefetch;

  logic        clk;
  logic        reset;
  logic        req_valid;
  logic        req_ready;
  logic [31:0] req_addr;
  logic [31:0] req_rdata;
  logic        mem_valid;
  logic        mem_ready;
  logic [31:0] mem_addr;
  logic [31:0] mem_rdata;
  logic        mem_instr;
  logic [31:0] pf_hit_count;

  int checks = 0;
  int errors = 0;

  // Bus model state
  int lat = 0;
  int wait_cnt = 0;
  int bus_txn = 0;
  int rr_cnt = 0;
  int stab_err = 0;
  bit seen_110 = 1'b0;
  bit prev_pend = 1'b0;
  logic [31:0] prev_addr = 32'd0;

  icache_mem_prefetch #(.LINE_WORDS(4), .PREFETCH_EN(1'b1)) dut (
    .clk          (clk),
    .reset        (reset),
    .req_valid    (req_valid),
    .req_ready    (req_ready),
    .req_addr     (req_addr),
    .req_rdata    (req_rdata),
    .mem_valid    (mem_valid),
    .mem_ready    (mem_ready),
    .mem_addr     (mem_addr),
    .mem_rdata    (mem_rdata),
    .mem_instr    (mem_instr),
    .pf_hit_count (pf_hit_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Memory: data word is the address xor a fixed pattern; completes after lat waits.
  assign mem_ready = mem_valid && (wait_cnt >= lat);
  assign mem_rdata = mem_valid ? (mem_addr ^ 32'h5A5A_0000) : 32'd0;

  always @(posedge clk) begin
    if (!mem_valid || mem_ready) wait_cnt <= 0;
    else                         wait_cnt <= wait_cnt + 1;
    if (mem_valid && mem_ready) bus_txn <= bus_txn + 1;
    if (mem_valid && mem_addr == 32'h110) seen_110 <= 1'b1;
    if (req_ready) rr_cnt <= rr_cnt + 1;
    if (prev_pend && (!mem_valid || mem_addr != prev_addr)) stab_err <= stab_err + 1;
    prev_pend <= mem_valid && !mem_ready && !reset;
    prev_addr <= mem_addr;
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  task automatic issue(input logic [31:0] a);
    req_valid = 1'b1;
    req_addr  = a;
  endtask

  // Wait (bounded) for req_ready, check latency and data, then drop valid one cycle.
  task automatic wait_ready(input string tag, input int exp_cyc, input logic [31:0] exp_data);
    int n;
    n = 0;
    do begin
      step();
      n++;
    end while (!req_ready && n < 40);
    chk({tag, "_ready"}, 32'(req_ready), 32'd1);
    chk({tag, "_lat"}, 32'(n), 32'(exp_cyc));
    chk({tag, "_data"}, req_rdata, exp_data);
    req_valid = 1'b0;
    step();
    chk({tag, "_pulse"}, 32'(req_ready), 32'd0);
  endtask

  task automatic do_reset();
    reset     = 1'b1;
    req_valid = 1'b0;
    step();
    reset = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int base_txn;
    int base_rr;
    reset     = 1'b1;
    req_valid = 1'b0;
    req_addr  = 32'd0;
    step();
    step();

    // Reset values
    chk("rst_req_ready", 32'(req_ready), 32'd0);
    chk("rst_req_rdata", req_rdata, 32'd0);
    chk("rst_mem_valid", 32'(mem_valid), 32'd0);
    chk("rst_mem_addr", mem_addr, 32'd0);
    chk("rst_pf_hits", pf_hit_count, 32'd0);
    chk("mem_instr", 32'(mem_instr), 32'd1);
    reset = 1'b0;

    // T1: miss on 0x100, 3-cycle bus latency, then prefetch of 0x104
    lat = 3;
    issue(32'h100);
    step();
    chk("t1_mem_valid", 32'(mem_valid), 32'd1);
    chk("t1_mem_addr", mem_addr, 32'h100);
    chk("t1_ready_early", 32'(req_ready), 32'd0);
    step();
    step();
    step();
    chk("t1_bus_ready", 32'(mem_ready), 32'd1);
    chk("t1_ready_wait", 32'(req_ready), 32'd0);
    step();
    chk("t1_req_ready", 32'(req_ready), 32'd1);
    chk("t1_req_rdata", req_rdata, 32'h5A5A_0100);
    chk("t1_pf_valid", 32'(mem_valid), 32'd1);
    chk("t1_pf_addr", mem_addr, 32'h104);
    req_valid = 1'b0;
    step();
    chk("t1_pulse", 32'(req_ready), 32'd0);
    chk("t1_pf_addr_held", mem_addr, 32'h104);

    // T2: full line refill, zero-wait bus; words 2..4 from the buffer
    do_reset();
    lat = 0;
    base_txn = bus_txn;
    issue(32'h100);
    wait_ready("t2_w0", 2, 32'h5A5A_0100);
    issue(32'h104);
    wait_ready("t2_w1", 1, 32'h5A5A_0104);
    issue(32'h108);
    wait_ready("t2_w2", 1, 32'h5A5A_0108);
    issue(32'h10C);
    wait_ready("t2_w3", 1, 32'h5A5A_010C);
    step();
    chk("t2_hits", pf_hit_count, 32'd3);
    chk("t2_bus_idle", 32'(mem_valid), 32'd0);
    chk("t2_bus_txns", 32'(bus_txn - base_txn), 32'd4);
    chk("t2_no_0x110", 32'(seen_110), 32'd0);

    // T3: last word of a line on a miss: served, no prefetch follows
    do_reset();
    lat = 1;
    base_txn = bus_txn;
    issue(32'h10C);
    wait_ready("t3_last", 3, 32'h5A5A_010C);
    chk("t3_bus_idle0", 32'(mem_valid), 32'd0);
    step();
    step();
    step();
    chk("t3_bus_idle3", 32'(mem_valid), 32'd0);
    chk("t3_bus_txns", 32'(bus_txn - base_txn), 32'd1);

    // T4: prefetch of 0x104 in flight when the cache jumps to 0x200
    do_reset();
    lat = 3;
    issue(32'h100);
    wait_ready("t4_first", 5, 32'h5A5A_0100);
    issue(32'h200);
    step();
    chk("t4_hold_valid_a", 32'(mem_valid), 32'd1);
    chk("t4_hold_addr_a", mem_addr, 32'h104);
    chk("t4_no_ready_a", 32'(req_ready), 32'd0);
    step();
    chk("t4_hold_valid_b", 32'(mem_valid), 32'd1);
    chk("t4_hold_addr_b", mem_addr, 32'h104);
    step();
    chk("t4_pf_done", 32'(mem_valid), 32'd0);
    chk("t4_no_ready_c", 32'(req_ready), 32'd0);
    step();
    chk("t4_miss_valid", 32'(mem_valid), 32'd1);
    chk("t4_miss_addr", mem_addr, 32'h200);
    wait_ready("t4_miss", 4, 32'h5A5A_0200);
    chk("t4_hits", pf_hit_count, 32'd0);

    // T5: requester drops mid-fetch of 0x300, then comes back for it
    do_reset();
    lat = 2;
    issue(32'h300);
    step();
    chk("t5_mem_addr", mem_addr, 32'h300);
    req_valid = 1'b0;
    base_rr = rr_cnt;
    step();
    chk("t5_no_ready_a", 32'(req_ready), 32'd0);
    step();
    chk("t5_no_ready_b", 32'(req_ready), 32'd0);
    step();
    chk("t5_no_ready_c", 32'(req_ready), 32'd0);
    chk("t5_bus_idle", 32'(mem_valid), 32'd0);
    chk("t5_no_pulses", 32'(rr_cnt - base_rr), 32'd0);
    issue(32'h300);
    wait_ready("t5_hit", 1, 32'h5A5A_0300);
    chk("t5_hits", pf_hit_count, 32'd1);
    chk("t5_pf_valid", 32'(mem_valid), 32'd1);
    chk("t5_pf_addr", mem_addr, 32'h304);

    // T6: reset with the 0x304 prefetch still outstanding
    reset = 1'b1;
    step();
    chk("t6_mem_valid", 32'(mem_valid), 32'd0);
    chk("t6_req_ready", 32'(req_ready), 32'd0);
    chk("t6_pf_valid", 32'(dut.pf_valid), 32'd0);
    chk("t6_hits", pf_hit_count, 32'd0);
    chk("t6_mem_addr", mem_addr, 32'd0);
    reset = 1'b0;
    issue(32'h304);
    wait_ready("t6_cold", 4, 32'h5A5A_0304);
    chk("t6_hits_after", pf_hit_count, 32'd0);

    chk("bus_stable", 32'(stab_err), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/icache_mem_prefetch.md
Name: icache_mem_prefetch

Overview:
- Sits directly downstream of the direct-mapped instruction cache's refill port and converts its word-at-a-time refill requests to the native valid/ready memory bus.
- Holds a single-word next-line-word prefetch buffer, so sequential refill words after the first are usually served without a memory round trip.
- Read-only; instruction fetch path only.

Parameters:
- LINE_WORDS, 4, words per cache line; power of two, 2..16; prefetch never crosses a line boundary.
- PREFETCH_EN, 1, 1 = issue next-word prefetch after each served word; 0 = pure pass-through adapter.

Ports:
- clk  in  1  clock; all logic on rising edge.
- reset  in  1  synchronous, active-high reset.
- req_valid  in  1  cache refill request; held high, with req_addr stable, until req_ready is seen.
- req_ready  out  1  one-cycle pulse; req_rdata valid in the same cycle.
- req_addr  in  32  refill word address; bits [1:0] ignored.
- req_rdata  out  32  refill data.
- mem_valid  out  1  native bus request; held until mem_ready.
- mem_ready  in  1  native bus completion; mem_rdata valid in the same cycle.
- mem_addr  out  32  word-aligned bus address.
- mem_rdata  in  32  bus read data.
- mem_instr  out  1  constant 1.
- pf_hit_count  out  32  count of requests served from the prefetch buffer; saturates at all-ones.

Behaviour:
- Reset values:
  - req_ready=0, req_rdata=0, mem_valid=0, mem_addr=0, pf_hit_count=0.
  - Prefetch buffer invalid (pf_valid=0); state IDLE.
  - Reset mid-transaction drops mem_valid the next edge; the outstanding bus transaction is abandoned.
- All outputs are registered. Word index is addr[log2(LINE_WORDS)+1:2]. last_word means word index == LINE_WORDS-1.
- req_ready is asserted only while req_valid=1 and only for one cycle. It is always 0 the cycle after a pulse, even if req_valid stays high (the cache drops valid for one cycle between words).
- The bus transaction is never aborted. mem_addr and mem_valid are stable from assertion until mem_ready.
- States:
  - IDLE:
    - req_valid=1, req_ready=0, pf_valid=1 and pf_addr==req_addr[31:2]: pulse req_ready with pf_data, clear pf_valid, increment pf_hit_count. If PREFETCH_EN and not last_word, go to PREFETCH with target req_addr+4; else stay IDLE.
    - req_valid=1 without a buffer match: clear pf_valid, assert mem_valid with mem_addr={req_addr[31:2],2'b00}, go to FETCH.
    - Otherwise stay IDLE.
  - FETCH (waits for mem_ready). On mem_ready, deassert mem_valid, then:
    - If req_valid=1 and req_addr still matches mem_addr: pulse req_ready with mem_rdata. Go to PREFETCH (target mem_addr+4) if PREFETCH_EN and not last_word; else IDLE.
    - If req_valid=0 or the address changed: load mem_rdata into the prefetch buffer tagged mem_addr, set pf_valid, go to IDLE.
  - PREFETCH:
    - On entry cycle: assert mem_valid with the target address.
    - On mem_ready: deassert mem_valid, load the buffer (pf_addr=target, pf_data=mem_rdata, pf_valid=1), go to IDLE.
    - A demand request arriving during PREFETCH waits. It is evaluated in IDLE the cycle after completion, and hits if the addresses match.
- Latency:
  - Buffer hit: req_ready 1 cycle after req_valid is first sampled.
  - Miss: mem_valid 1 cycle after req_valid; req_ready 1 cycle after mem_ready.
  - Miss behind a prefetch: prefetch completion + 1 cycle + miss latency.
- Address arithmetic:
  - Prefetch target = served address + 4 within the same line. It never wraps to word 0 and never crosses the line.
  - 32-bit address; no carry beyond bit 31 is possible because last_word blocks the increment.
- With PREFETCH_EN=0, pf_valid never sets via PREFETCH. It may still set via the abandoned-FETCH path.

Test Plan:
- Reset, then req_addr=0x100 with a 3-cycle bus latency -> mem_valid at cycle 1 with mem_addr=0x100; req_ready pulse with req_rdata=mem[0x100] 1 cycle after mem_ready; PREFETCH then issues mem_addr=0x104.
- Full 4-word refill 0x100..0x10C in cache-style sequence (valid, ready, drop one cycle, next address), zero-wait bus -> words 2..4 served from the buffer; pf_hit_count=3; no bus request to 0x110.
- Request 0x10C (last word) on a miss -> served; no prefetch issued; state IDLE; mem_valid stays 0 afterwards.
- Prefetch of 0x104 outstanding, then cache requests 0x200 -> mem_valid held for 0x104 until mem_ready; then 0x200 fetched; buffer miss; pf_hit_count unchanged.
- req_valid dropped mid-FETCH of 0x300, then re-requested as 0x300 -> no req_ready pulse during the drop; re-request served from the buffer 1 cycle later; pf_hit_count +1.
- reset asserted while mem_valid=1 -> next edge: mem_valid=0, req_ready=0, pf_valid=0, pf_hit_count=0; a subsequent request behaves as a cold miss.
